// File: rtl/lsz_idx.sv
// Least-significant-zero index finder: a binary tree of 2:1 priority merge
// cells feeding a single output register stage (one-cycle latency, no handshake).
module lsz_idx #(
  parameter int IWID = 4,
  parameter int IWL2 = $clog2(IWID)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IWID-1:0]   in,
  output logic [IWL2-1:0]   lszIdx,
  output logic              allOne
);

  localparam int P = 1 << IWL2;

  // Lanes above IWID are padded with '1' so they can never be reported as a zero.
  logic [P-1:0] w_pad;
  always_comb begin
    w_pad = '1;
    w_pad[IWID-1:0] = in;
  end

  for (genvar lv = 0; lv <= IWL2; lv++) begin : g_lvl
    localparam int N = P >> lv;
    logic [N-1:0]    w_hz;
    logic [IWL2-1:0] w_idx [N];
    for (genvar n = 0; n < N; n++) begin : g_node
      if (lv == 0) begin : g_leaf
        assign w_hz[n]  = ~w_pad[n];
        assign w_idx[n] = IWL2'(n);
      end else begin : g_merge
        // Lower half wins whenever it holds a zero.
        assign w_hz[n]  = g_lvl[lv-1].w_hz[2*n] | g_lvl[lv-1].w_hz[2*n+1];
        assign w_idx[n] = g_lvl[lv-1].w_hz[2*n] ? g_lvl[lv-1].w_idx[2*n]
                                                : g_lvl[lv-1].w_idx[2*n+1];
      end
    end
  end

  logic            w_top_hz;
  logic [IWL2-1:0] w_top_idx;
  assign w_top_hz  = g_lvl[IWL2].w_hz[0];
  assign w_top_idx = g_lvl[IWL2].w_idx[0];

  logic [IWL2-1:0] r_idx;
  logic            r_all;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
      r_all <= 1'b0;
    end else begin
      r_idx <= w_top_hz ? w_top_idx : '0;
      r_all <= ~w_top_hz;
    end
  end

  assign lszIdx = r_idx;
  assign allOne = r_all;

endmodule

// File: tb/tb_lsz_idx.sv
// Bench for lsz_idx: IWID=4 and IWID=5 instances, directed tables, a wrapping
// sweep against a bit-loop reference model, and reset corner sequences.
module tb_lsz_idx;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in4;
  logic [1:0] idx4;
  logic       all4;
  logic [4:0] in5;
  logic [2:0] idx5;
  logic       all5;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lsz_idx #(.IWID(4)) u_dut4 (
    .clk    (clk),
    .rst    (rst),
    .in     (in4),
    .lszIdx (idx4),
    .allOne (all4)
  );

  lsz_idx #(.IWID(5)) u_dut5 (
    .clk    (clk),
    .rst    (rst),
    .in     (in5),
    .lszIdx (idx5),
    .allOne (all5)
  );

  typedef struct {
    logic [3:0] vin;
    logic [1:0] idx;
    logic       all;
  } vec4_t;

  typedef struct {
    logic [4:0] vin;
    logic [2:0] idx;
    logic       all;
  } vec5_t;

  vec4_t t4 [7];
  vec5_t t5 [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: scan upward for the first zero; all-ones reports index 0.
  function automatic int ref_idx(input logic [31:0] v, input int w);
    for (int i = 0; i < w; i++) if (v[i] == 1'b0) return i;
    return 0;
  endfunction

  function automatic logic ref_all(input logic [31:0] v, input int w);
    for (int i = 0; i < w; i++) if (v[i] == 1'b0) return 1'b0;
    return 1'b1;
  endfunction

  // Drive new inputs away from the edge, then sample just after the capturing edge.
  task automatic apply(input logic [3:0] v4, input logic [4:0] v5);
    @(negedge clk);
    in4 = v4;
    in5 = v5;
    @(posedge clk);
    #1;
  endtask

  task automatic check_models(input string tag);
    chk({tag, "_idx4"}, 32'(idx4), 32'(ref_idx(32'(in4), 4)));
    chk({tag, "_all4"}, 32'(all4), 32'(ref_all(32'(in4), 4)));
    chk({tag, "_idx5"}, 32'(idx5), 32'(ref_idx(32'(in5), 5)));
    chk({tag, "_all5"}, 32'(all5), 32'(ref_all(32'(in5), 5)));
    chk({tag, "_idx5_range"}, 32'(idx5 <= 3'd4), 32'd1);
  endtask

  initial begin
    t4[0] = '{4'b0000, 2'd0, 1'b0};
    t4[1] = '{4'b0001, 2'd1, 1'b0};
    t4[2] = '{4'b0011, 2'd2, 1'b0};
    t4[3] = '{4'b0111, 2'd3, 1'b0};
    t4[4] = '{4'b1011, 2'd2, 1'b0};
    t4[5] = '{4'b1111, 2'd0, 1'b1};
    t4[6] = '{4'b1110, 2'd0, 1'b0};

    t5[0] = '{5'b01111, 3'd4, 1'b0};
    t5[1] = '{5'b11111, 3'd0, 1'b1};
    t5[2] = '{5'b00000, 3'd0, 1'b0};
    t5[3] = '{5'b10111, 3'd3, 1'b0};
    t5[4] = '{5'b11110, 3'd0, 1'b0};
    t5[5] = '{5'b11101, 3'd1, 1'b0};

    // Reset asserted from time zero: outputs cleared before any clock edge.
    rst = 1'b1;
    in4 = 4'b0110;
    in5 = 5'b11111;
    #1;
    chk("rst_async_idx4", 32'(idx4), 32'd0);
    chk("rst_async_all4", 32'(all4), 32'd0);
    chk("rst_async_all5", 32'(all5), 32'd0);
    // Edges under reset must not load all-ones data.
    in4 = 4'b1111;
    @(posedge clk);
    #1;
    chk("rst_hold_all4", 32'(all4), 32'd0);
    chk("rst_hold_all5", 32'(all5), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    in4 = 4'b0110;
    @(posedge clk);
    #1;
    chk("rst_rel_idx4", 32'(idx4), 32'd0);
    chk("rst_rel_all4", 32'(all4), 32'd0);
    chk("rst_rel_all5", 32'(all5), 32'd1);

    for (int i = 0; i < 7; i++) begin
      apply(t4[i].vin, 5'b00000);
      chk($sformatf("tbl4_%0d_idx", i), 32'(idx4), 32'(t4[i].idx));
      chk($sformatf("tbl4_%0d_all", i), 32'(all4), 32'(t4[i].all));
    end

    for (int i = 0; i < 6; i++) begin
      apply(4'b0000, t5[i].vin);
      chk($sformatf("tbl5_%0d_idx", i), 32'(idx5), 32'(t5[i].idx));
      chk($sformatf("tbl5_%0d_all", i), 32'(all5), 32'(t5[i].all));
    end

    // Latency: an input held only between edges must appear exactly one edge later.
    apply(4'b0011, 5'b00111);
    @(negedge clk);
    in4 = 4'b0000;
    in5 = 5'b00000;
    #1;
    chk("lat_hold_idx4", 32'(idx4), 32'd2);
    chk("lat_hold_idx5", 32'(idx5), 32'd3);
    @(posedge clk);
    #1;
    chk("lat_next_idx4", 32'(idx4), 32'd0);

    for (int i = 0; i < 500; i++) begin
      if (i == 200) begin
        // Previous step left in4 = 7 (index 3) so a clear is observable.
        chk("pre_mid_rst_idx4", 32'(idx4), 32'd3);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_idx4", 32'(idx4), 32'd0);
        chk("mid_rst_all4", 32'(all4), 32'd0);
        chk("mid_rst_idx5", 32'(idx5), 32'd0);
        @(posedge clk);
        #1;
        chk("mid_rst_hold_idx4", 32'(idx4), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        in4 = 4'(i);
        in5 = 5'(i);
        @(posedge clk);
        #1;
        check_models("post_rst");
      end else begin
        apply(4'(i), 5'(i));
        check_models($sformatf("sweep_%0d", i));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsz_idx.md
LSZ_IDX -- requirements
Module: lsz_idx

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; clock port `clk`, reset port `rst`.
REQ-002 The block SHALL have parameter IWID, default 4, giving the input vector width; legal values are 2 or more, and need not be a power of two.
REQ-003 The block SHALL have parameter IWL2, default $clog2(IWID), giving the index width; it is derived from IWID and is not overridden.
REQ-004 Port: clk  input  1  rising-edge clock for all state.
REQ-005 Port: rst  input  1  asynchronous active-high reset.
REQ-006 Port: in  input  IWID  vector to scan; bit 0 is the least significant bit.
REQ-007 Port: lszIdx  output  IWL2  registered index of the least significant '0' bit of `in`.
REQ-008 Port: allOne  output  1  registered flag; 1 when `in` contains no '0' bit.

Function
REQ-009 The combinational core SHALL compute idx = the smallest i (0..IWID-1) with in[i]==0 (least-significant-zero priority encode).
REQ-010 The core SHALL be built as a log2-depth binary tree of 2:1 priority merge cells; each cell emits (hasZero, idx) and prefers the lower half; odd widths pad upper lanes with '1'.
REQ-011 If all IWID bits are '1', the core SHALL produce idx = 0 and allOne = 1; otherwise allOne = 0.
REQ-012 lszIdx and allOne SHALL be registered on the rising clk edge: latency exactly 1 cycle from `in` to outputs.
REQ-013 Throughput SHALL be one new input per cycle; there is no handshake, and the outputs always reflect the previous cycle's `in`.
REQ-014 Bit 0 being '0' SHALL yield lszIdx = 0, allOne = 0, independent of higher bits.
REQ-015 For IWID not a power of two, lszIdx SHALL never exceed IWID-1.
REQ-016 X/Z on `in` is not supported; the outputs are undefined for such inputs.

Reset
REQ-017 While rst = 1, lszIdx SHALL be 0 and allOne SHALL be 0, asynchronously (not waiting for clk).
REQ-018 After rst deasserts, the first clk edge SHALL load the outputs from the current `in`.
REQ-019 A reset asserted mid-stream SHALL clear the outputs immediately; no stale value SHALL appear after release.

Verification
REQ-020 Reset: assert rst with in = 4'b0110 -> lszIdx = 0, allOne = 0 before any clk edge; release -> next edge gives lszIdx = 0.
REQ-021 Directed, IWID = 4, one edge each:
- in = 4'b0000 -> lszIdx = 0, allOne = 0
- in = 4'b0001 -> lszIdx = 1
- in = 4'b0011 -> lszIdx = 2
- in = 4'b0111 -> lszIdx = 3
- in = 4'b1011 -> lszIdx = 2
REQ-022 All ones, IWID = 4: in = 4'b1111 -> lszIdx = 0, allOne = 1; then in = 4'b1110 -> lszIdx = 0, allOne = 0.
REQ-023 Sweep: start in = 0 and increment `in` every 10 ns for 500 steps, wrapping modulo 16. Each cycle's outputs SHALL match a reference model applied to the prior cycle's `in`, including every all-ones wrap point.
REQ-024 Non-power-of-two, IWID = 5 (IWL2 = 3):
- in = 5'b01111 -> lszIdx = 4
- in = 5'b11111 -> lszIdx = 0, allOne = 1
REQ-025 Mid-stream reset: pulse rst during the sweep -> outputs are 0 within the reset pulse; the first post-release edge matches the model.
